// File: rtl/exec_cdb_unit.sv
// exec_cdb_unit: execute stage fed by the add and mul reservation stations.
// An add/sub unit and a mul/div unit run side by side and share a single
// common data bus (CDB) with a valid/ready handshake toward the ROB.
// Optional macro DIV_EN: when defined, func 0011 runs an iterative restoring
// divider (one quotient bit per cycle). When undefined, there is no divider
// logic, and func 0011 completes one cycle after accept with cdb_exc=1.
module exec_cdb_unit #(
  parameter int W       = 16,
  parameter int ROB_W   = 3,
  parameter int RD_W    = 4,
  parameter int RSI_W   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [W-1:0]     in_rs1data,
  input  logic [W-1:0]     in_rs2data,
  input  logic [ROB_W-1:0] in_rob_ind,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [RSI_W-1:0] in_rsindex,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [W-1:0]     cdb_data,
  output logic [ROB_W-1:0] cdb_rob_ind,
  output logic [RD_W-1:0]  cdb_rd,
  output logic [RSI_W-1:0] cdb_rsindex,
  output logic             cdb_unit,
  output logic             cdb_exc
);

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_MUL = 4'b0010;
  localparam logic [3:0] F_DIV = 4'b0011;

  localparam int MAXL  = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int CNT_W = $clog2(MAXL + 1);

  typedef enum logic {A_IDLE, A_DONE} add_st_e;
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_st_e;

  // Add unit state and result registers
  add_st_e          add_st_q, add_st_d;
  logic [W-1:0]     add_data_q, add_data_d;
  logic [ROB_W-1:0] add_rob_q, add_rob_d;
  logic [RD_W-1:0]  add_rd_q, add_rd_d;
  logic [RSI_W-1:0] add_rsi_q, add_rsi_d;
  logic             add_exc_q, add_exc_d;

  // Mul unit state; mul_data_q doubles as the quotient shift register
  mul_st_e          mul_st_q, mul_st_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] mul_lat;
  logic [W-1:0]     mul_data_q, mul_data_d;
  logic [ROB_W-1:0] mul_rob_q, mul_rob_d;
  logic [RD_W-1:0]  mul_rd_q, mul_rd_d;
  logic [RSI_W-1:0] mul_rsi_q, mul_rsi_d;
  logic             mul_exc_q, mul_exc_d;
`ifdef DIV_EN
  logic             mul_isdiv_q, mul_isdiv_d;
  logic [W-1:0]     mul_rem_q, mul_rem_d;
  logic [W-1:0]     mul_dvs_q, mul_dvs_d;
`endif

  // CDB grant lock: keeps a stalled winner on the bus until it is taken
  logic lock_q, lock_d;
  logic lock_mul_q, lock_mul_d;

  logic         to_mul;
  logic         acc;
  logic         gnt_mul;
  logic         hs;
  logic [W-1:0] mul_lo;
  logic [W:0]   add_res;

  // {exc, data} of the add unit; anything that is not add/sub is illegal here
  function automatic logic [W:0] add_alu(input logic [3:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0] r;
    case (f)
      F_ADD:   r = {1'b0, a + b};
      F_SUB:   r = {1'b0, a - b};
      default: r = {1'b1, {W{1'b0}}};
    endcase
    return r;
  endfunction

`ifdef DIV_EN
  // One restoring-division step: returns {remainder, quotient} after shifting in one bit.
  // With a zero divisor every trial succeeds, so the quotient fills with ones.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem, input logic [W-1:0] quo,
                                              input logic [W-1:0] dvs);
    logic [W:0]   sh;
    logic [W-1:0] diff;
    sh   = {rem, quo[W-1]};
    diff = sh[W-1:0] - dvs;
    if (sh >= {1'b0, dvs}) return {diff, quo[W-2:0], 1'b1};
    else                   return {sh[W-1:0], quo[W-2:0], 1'b0};
  endfunction
`endif

  assign to_mul   = (in_func == F_MUL) || (in_func == F_DIV);
  assign in_ready = rst_n && (to_mul ? (mul_st_q == M_IDLE) : (add_st_q == A_IDLE));
  assign acc      = in_valid && in_ready;
  assign mul_lo   = in_rs1data * in_rs2data;
  assign add_res  = add_alu(in_func, in_rs1data, in_rs2data);

  // Grant: a locked (stalled) winner keeps the bus, otherwise mul has priority
  assign gnt_mul = lock_q ? lock_mul_q : (mul_st_q == M_DONE);
  assign hs      = cdb_valid && cdb_ready;

  // CDB drive: selected unit's fields when it is DONE, all zero otherwise
  always_comb begin
    cdb_valid   = 1'b0;
    cdb_data    = '0;
    cdb_rob_ind = '0;
    cdb_rd      = '0;
    cdb_rsindex = '0;
    cdb_unit    = 1'b0;
    cdb_exc     = 1'b0;
    if (gnt_mul) begin
      if (mul_st_q == M_DONE) begin
        cdb_valid   = 1'b1;
        cdb_data    = mul_data_q;
        cdb_rob_ind = mul_rob_q;
        cdb_rd      = mul_rd_q;
        cdb_rsindex = mul_rsi_q;
        cdb_unit    = 1'b1;
        cdb_exc     = mul_exc_q;
      end
    end else if (add_st_q == A_DONE) begin
      cdb_valid   = 1'b1;
      cdb_data    = add_data_q;
      cdb_rob_ind = add_rob_q;
      cdb_rd      = add_rd_q;
      cdb_rsindex = add_rsi_q;
      cdb_exc     = add_exc_q;
    end
  end

  // Lock next state: hold the current grant across a stall
  always_comb begin
    lock_d     = cdb_valid && !cdb_ready;
    lock_mul_d = gnt_mul;
  end

  // Add unit next state: IDLE -> DONE on accept, DONE -> IDLE on its handshake
  always_comb begin
    add_st_d   = add_st_q;
    add_data_d = add_data_q;
    add_rob_d  = add_rob_q;
    add_rd_d   = add_rd_q;
    add_rsi_d  = add_rsi_q;
    add_exc_d  = add_exc_q;
    if (add_st_q == A_IDLE) begin
      if (acc && !to_mul) begin
        add_st_d   = A_DONE;
        add_data_d = add_res[W-1:0];
        add_exc_d  = add_res[W];
        add_rob_d  = in_rob_ind;
        add_rd_d   = in_rd;
        add_rsi_d  = in_rsindex;
      end
    end else if (hs && !gnt_mul) begin
      add_st_d = A_IDLE;
    end
  end

  // Mul unit next state: accept loads operands and latency, BUSY counts down
  always_comb begin
    mul_st_d   = mul_st_q;
    mul_cnt_d  = mul_cnt_q;
    mul_lat    = CNT_W'(MUL_LAT);
    mul_data_d = mul_data_q;
    mul_rob_d  = mul_rob_q;
    mul_rd_d   = mul_rd_q;
    mul_rsi_d  = mul_rsi_q;
    mul_exc_d  = mul_exc_q;
`ifdef DIV_EN
    mul_isdiv_d = mul_isdiv_q;
    mul_rem_d   = mul_rem_q;
    mul_dvs_d   = mul_dvs_q;
`endif
    case (mul_st_q)
      M_IDLE: begin
        if (acc && to_mul) begin
          mul_rob_d  = in_rob_ind;
          mul_rd_d   = in_rd;
          mul_rsi_d  = in_rsindex;
          mul_data_d = mul_lo;
          mul_exc_d  = 1'b0;
`ifdef DIV_EN
          mul_isdiv_d = 1'b0;
          if (in_func == F_DIV) begin
            // First quotient bit is resolved in the accept cycle
            mul_isdiv_d             = 1'b1;
            {mul_rem_d, mul_data_d} = div_step({W{1'b0}}, in_rs1data, in_rs2data);
            mul_dvs_d               = in_rs2data;
            mul_exc_d               = (in_rs2data == {W{1'b0}});
            mul_lat                 = CNT_W'(W);
          end
`else
          if (in_func == F_DIV) begin
            mul_data_d = '0;
            mul_exc_d  = 1'b1;
            mul_lat    = CNT_W'(1);
          end
`endif
          if (mul_lat == CNT_W'(1)) begin
            mul_st_d = M_DONE;
          end else begin
            mul_st_d  = M_BUSY;
            mul_cnt_d = mul_lat - CNT_W'(1);
          end
        end
      end
      M_BUSY: begin
`ifdef DIV_EN
        if (mul_isdiv_q) begin
          {mul_rem_d, mul_data_d} = div_step(mul_rem_q, mul_data_q, mul_dvs_q);
        end
`endif
        mul_cnt_d = mul_cnt_q - CNT_W'(1);
        if (mul_cnt_q == CNT_W'(1)) mul_st_d = M_DONE;
      end
      M_DONE: begin
        if (hs && gnt_mul) mul_st_d = M_IDLE;
      end
      default: mul_st_d = M_IDLE;
    endcase
  end

  // Control registers: synchronous active-low reset drops any in-flight op
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      add_st_q   <= A_IDLE;
      mul_st_q   <= M_IDLE;
      mul_cnt_q  <= '0;
      lock_q     <= 1'b0;
      lock_mul_q <= 1'b0;
    end else begin
      add_st_q   <= add_st_d;
      mul_st_q   <= mul_st_d;
      mul_cnt_q  <= mul_cnt_d;
      lock_q     <= lock_d;
      lock_mul_q <= lock_mul_d;
    end
  end

  // Data registers: only observed while their unit is DONE, so no reset
  always_ff @(posedge clk1) begin
    add_data_q <= add_data_d;
    add_rob_q  <= add_rob_d;
    add_rd_q   <= add_rd_d;
    add_rsi_q  <= add_rsi_d;
    add_exc_q  <= add_exc_d;
    mul_data_q <= mul_data_d;
    mul_rob_q  <= mul_rob_d;
    mul_rd_q   <= mul_rd_d;
    mul_rsi_q  <= mul_rsi_d;
    mul_exc_q  <= mul_exc_d;
`ifdef DIV_EN
    mul_isdiv_q <= mul_isdiv_d;
    mul_rem_q   <= mul_rem_d;
    mul_dvs_q   <= mul_dvs_d;
`endif
  end

endmodule
